pokey_audio_dac: RTL and testbench

POKEY_AUDIO_DAC -- requirements
Module: pokey_audio_dac

---
 rtl/pokey_pkg.sv | 18 +
 rtl/pokey_mute_ramp.sv | 82 ++++++++
 rtl/pokey_audio_dac.sv | 85 ++++++++
 tb/tb_pokey_audio_dac.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY audio DAC: default widths, modulator
// mode encodings and the mute ramp state enumeration.
package pokey_pkg;

  localparam int AUD_W_DEF = 6;
  localparam int CNT_W_DEF = 6;

  localparam logic MODE_SD  = 1'b0;
  localparam logic MODE_PWM = 1'b1;

  typedef enum logic [1:0] {
    UNMUTED   = 2'd0,
    RAMP_DOWN = 2'd1,
    MUTED     = 2'd2,
    RAMP_UP   = 2'd3
  } mute_state_t;

endpackage

// File: rtl/pokey_mute_ramp.sv
// Click-free mute controller: ramps a level register r between silence and
// the held sample one step per sample strobe, and limits the output to min(r,s).
module pokey_mute_ramp
  import pokey_pkg::*;
#(
  parameter int AUD_W = AUD_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AUD_W-1:0] s,
  input  logic             sample_en,
  input  logic             mute,
  output logic [AUD_W-1:0] v,
  output logic             muted
);

  localparam logic [AUD_W-1:0] ONE   = {{(AUD_W-1){1'b0}}, 1'b1};
  localparam logic [AUD_W-1:0] R_MAX = {AUD_W{1'b1}};

  mute_state_t      state, state_next;
  logic [AUD_W-1:0] r, r_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MUTED;
      r     <= '0;
    end else begin
      state <= state_next;
      r     <= r_next;
    end
  end

  // A mute edge during a ramp reverses direction at once, keeping r.
  always_comb begin
    state_next = state;
    r_next     = r;
    unique case (state)
      UNMUTED: begin
        if (sample_en) r_next = s;
        if (mute) state_next = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (!mute) begin
          state_next = RAMP_UP;
        end else if (r == '0) begin
          state_next = MUTED;
        end else if (sample_en) begin
          r_next = r - ONE;
          if (r == ONE) state_next = MUTED;
        end
      end
      MUTED: begin
        r_next = '0;
        if (!mute) state_next = RAMP_UP;
      end
      RAMP_UP: begin
        if (mute) begin
          state_next = RAMP_DOWN;
        end else if (sample_en) begin
          if (r >= s) begin
            state_next = UNMUTED;
          end else begin
            r_next = (r == R_MAX) ? r : r + ONE;
            if (r_next >= s) state_next = UNMUTED;
          end
        end
      end
      default: begin
        state_next = MUTED;
        r_next     = '0;
      end
    endcase
  end

  always_comb begin
    v = s;
    if (state != UNMUTED) v = (r < s) ? r : s;
  end

  assign muted = (state == MUTED);

endmodule

// File: rtl/pokey_audio_dac.sv
// 1-bit audio DAC for the POKEY summed output: sample hold, mute ramp,
// volume shift, and a selectable first-order sigma-delta or PWM modulator.
module pokey_audio_dac
  import pokey_pkg::*;
#(
  parameter int AUD_W = AUD_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AUD_W-1:0] audio,
  input  logic             sample_en,
  input  logic             mode,
  input  logic             mute,
  input  logic [1:0]       vol,
  output logic             dac_out,
  output logic             frame,
  output logic             muted
);

  localparam int CMP_W = (AUD_W > CNT_W) ? AUD_W : CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [AUD_W-1:0] s_q, s_cur, v, e, compare;
  logic [AUD_W:0]   acc, acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             mode_q, wrap, mode_change, pwm_bit;

  // The ramp sees the freshly captured sample so a strobe and a mute edge
  // in the same clock act on the new value.
  assign s_cur = sample_en ? audio : s_q;

  pokey_mute_ramp #(.AUD_W(AUD_W)) u_ramp (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s_cur),
    .sample_en (sample_en),
    .mute      (mute),
    .v         (v),
    .muted     (muted)
  );

  assign e           = v >> vol;
  assign acc_sum     = {1'b0, acc[AUD_W-1:0]} + {1'b0, e};
  assign wrap        = (cnt == {CNT_W{1'b1}});
  assign frame       = wrap;
  assign mode_change = wrap && (mode != mode_q);
  assign pwm_bit     = (CMP_W'(cnt) < CMP_W'(compare));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      cnt <= '0;
    end else begin
      if (sample_en) s_q <= audio;
      cnt <= cnt + CNT_ONE;
    end
  end

  // Mode and PWM duty only change on frame boundaries so no partial frame is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_SD;
      compare <= '0;
      acc     <= '0;
    end else begin
      if (wrap) begin
        mode_q  <= mode;
        compare <= mode_change ? '0 : e;
      end
      acc <= mode_change ? '0 : acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_out <= 1'b0;
    end else if (mode_q == MODE_PWM) begin
      dac_out <= pwm_bit;
    end else begin
      dac_out <= acc_sum[AUD_W];
    end
  end

endmodule

// File: tb/tb_pokey_audio_dac.sv
// Directed bench for pokey_audio_dac: power-up ramp, sigma-delta density,
// PWM duty and frame-aligned updates, mute ramp, and asynchronous reset.
module tb_pokey_audio_dac;
  import pokey_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       mode = 1'b0;
  logic       mute = 1'b0;
  logic [5:0] audio = '0;
  logic [1:0] vol = '0;
  logic       dac_out, frame, muted;

  int total = 0;
  int bad = 0;
  int ones, frames;
  logic found;

  always #5 clk = ~clk;

  pokey_audio_dac #(.AUD_W(6), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .audio     (audio),
    .sample_en (sample_en),
    .mode      (mode),
    .mute      (mute),
    .vol       (vol),
    .dac_out   (dac_out),
    .frame     (frame),
    .muted     (muted)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n strobes of the given sample, one every 4 clocks
  task automatic applyStimulus(input logic [5:0] value, input int n);
    for (int i = 0; i < n; i++) begin
      audio = value;
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic waitFrame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (frame === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic countWindow(input int action, output int n_ones, output int n_frames);
    n_ones = 0;
    n_frames = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (dac_out === 1'b1) n_ones++;
      if (frame === 1'b1) n_frames++;
      sample_en = 1'b0;
      if (i == 20 && action == 1) vol = 2'd2;
      if (i == 20 && action == 2) begin
        vol = 2'd0;
        audio = 6'd63;
        sample_en = 1'b1;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_dac_out", dac_out, 0);
    checkOutput("rst_frame", frame, 0);
    checkOutput("rst_muted", muted, 1);
    checkOutput("rst_r", dut.u_ramp.r, 0);
    checkOutput("rst_cnt", dut.cnt, 0);

    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("powerup_muted", muted, 0);
    checkOutput("powerup_state", dut.u_ramp.state, RAMP_UP);

    applyStimulus(6'd40, 39);
    checkOutput("ramp39_r", dut.u_ramp.r, 39);
    checkOutput("ramp39_state", dut.u_ramp.state, RAMP_UP);
    applyStimulus(6'd40, 1);
    checkOutput("ramp40_r", dut.u_ramp.r, 40);
    checkOutput("ramp40_state", dut.u_ramp.state, UNMUTED);
    checkOutput("ramp40_muted", muted, 0);

    applyStimulus(6'd21, 1);
    repeat (4) @(negedge clk);
    countWindow(0, ones, frames);
    checkOutput($sformatf("sd_e21_ones_%0d_in_20_22", ones), (ones >= 20 && ones <= 22), 1);

    applyStimulus(6'd40, 1);
    vol = 2'd1;
    repeat (4) @(negedge clk);
    countWindow(0, ones, frames);
    checkOutput($sformatf("sd_e20_ones_%0d_in_19_21", ones), (ones >= 19 && ones <= 21), 1);

    vol = 2'd0;
    applyStimulus(6'd0, 1);
    repeat (2) @(negedge clk);
    countWindow(0, ones, frames);
    checkOutput("sd_e0_ones", ones, 0);

    applyStimulus(6'd21, 1);
    waitFrame("pre_toggle");
    repeat (20) @(negedge clk);
    mode = MODE_PWM;
    @(negedge clk);
    checkOutput("toggle_mid_mode", dut.mode_q, MODE_SD);
    waitFrame("toggle");
    checkOutput("toggle_wrap_mode", dut.mode_q, MODE_SD);
    @(negedge clk);
    checkOutput("toggle_acc_clear", dut.acc, 0);
    checkOutput("toggle_new_mode", dut.mode_q, MODE_PWM);

    applyStimulus(6'd16, 1);
    waitFrame("pwm_load");
    countWindow(1, ones, frames);
    checkOutput("pwm_e16_ones", ones, 16);
    checkOutput("pwm_frame_pulses", frames, 1);
    countWindow(2, ones, frames);
    checkOutput("pwm_vol2_ones", ones, 4);
    countWindow(0, ones, frames);
    checkOutput("pwm_e63_ones", ones, 63);

    applyStimulus(6'd30, 1);
    checkOutput("track_r30", dut.u_ramp.r, 30);
    mute = 1'b1;
    @(negedge clk);
    checkOutput("mute_state", dut.u_ramp.state, RAMP_DOWN);
    applyStimulus(6'd30, 10);
    checkOutput("down10_r", dut.u_ramp.r, 20);
    checkOutput("down10_muted", muted, 0);
    mute = 1'b0;
    @(negedge clk);
    checkOutput("unmute_state", dut.u_ramp.state, RAMP_UP);
    checkOutput("unmute_r", dut.u_ramp.r, 20);
    mute = 1'b1;
    @(negedge clk);
    applyStimulus(6'd30, 19);
    checkOutput("down_r1", dut.u_ramp.r, 1);
    checkOutput("down_r1_muted", muted, 0);
    applyStimulus(6'd30, 1);
    checkOutput("down_r0_muted", muted, 1);
    checkOutput("down_r0_r", dut.u_ramp.r, 0);
    waitFrame("muted_frame");
    countWindow(0, ones, frames);
    checkOutput("muted_pwm_ones", ones, 0);

    mute = 1'b0;
    @(negedge clk);
    applyStimulus(6'd30, 25);
    checkOutput("rampup25_r", dut.u_ramp.r, 25);
    mute = 1'b1;
    @(negedge clk);
    checkOutput("rampdown_state", dut.u_ramp.state, RAMP_DOWN);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (dac_out === 1'b1) found = 1'b1;
    end
    checkOutput("rampdown_dac_active", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_dac_out", dac_out, 0);
    checkOutput("async_rst_muted", muted, 1);
    checkOutput("async_rst_frame", frame, 0);
    checkOutput("async_rst_r", dut.u_ramp.r, 0);
    checkOutput("async_rst_cnt", dut.cnt, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("held_mute_muted", muted, 1);
    mute = 1'b0;
    @(negedge clk);
    checkOutput("release_mute_muted", muted, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
